bus_datapath_seq: RTL and testbench
===================================

Name: bus_datapath_seq

Overview:
- Parametrised successor to the single-bus CPU datapath.
- Contains NREGS general registers, Y, Z (HI/LO halves), HI, LO, MAR and MDR, all sharing one internal WIDTH-bit bus.
- Adds a built-in micro-step sequencer: one start pulse runs a full register-register ALU op or a memory load, instead of a testbench driving every out/in strobe per cycle.
- Sits between the future control unit and the memory interface.

Parameters:
- WIDTH, 32, data/bus/register width.
- NREGS, 16, number of general registers (power of 2, >= 2).
- RW, $clog2(NREGS), register-select field width (derived, not overridden).

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  0=ADD 1=SUB 2=AND 3=OR 4=SHL 5=SHR 6=MUL 7=MOV 8=LOAD; 9-15 reserved.
- ra  in  RW  source A / load address register.
- rb  in  RW  source B.
- rc  in  RW  destination register.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- mem_req  out  1  read request.
- mem_addr  out  WIDTH  MAR contents.
- mem_ack  in  1  read data valid.
- mem_rdata  in  WIDTH  read data.
- dbg_sel  in  RW  debug register select.
- dbg_data  out  WIDTH  R[dbg_sel], combinational.
- hi_out  out  WIDTH  HI register.
- lo_out  out  WIDTH  LO register.

Behaviour:
- Reset (clear=1, asynchronous), taking effect immediately, including mid-operation:
  - all registers, Y, Z, HI, LO, MAR and MDR go to 0; state goes to IDLE.
  - busy=0, done=0, mem_req=0.
- Bus: exactly one source drives it per state; sources are decoded from state, not from external strobes.
- States: IDLE, T_Y, T_Z, T_WB, M_REQ, M_WB, DONE.
- IDLE:
  - start=1 latches op/ra/rb/rc.
  - Next state is T_Y, or DONE when op is reserved.
  - A reserved op writes nothing and still pulses done.
- T_Y:
  - bus=R[ra].
  - ALU ops: Y<=bus, next T_Z.
  - LOAD: MAR<=bus, next M_REQ.
- T_Z:
  - bus=R[rb].
  - Z<=f(Y,bus), next T_WB.
- ALU functions:
  - ADD/SUB wrap modulo 2^WIDTH; ZHI=0.
  - AND/OR are bitwise.
  - SHL/SHR are logical; shift amount = bus[$clog2(WIDTH)-1:0].
  - MUL is a signed WIDTH x WIDTH product into 2*WIDTH bits, split as ZHI:ZLO.
  - MOV passes bus (Y ignored).
- T_WB:
  - bus=ZLO, R[rc]<=bus.
  - MUL additionally: LO<=ZLO, HI<=ZHI, in the same cycle.
  - Next state is DONE.
- M_REQ:
  - mem_req=1, mem_addr=MAR.
  - Holds until mem_ack=1; on that edge MDR<=mem_rdata, next M_WB.
  - mem_ack outside M_REQ is ignored.
- M_WB: bus=MDR, R[rc]<=bus, next DONE.
- DONE: done=1 for exactly one cycle, next IDLE. A new start is accepted only on the following cycle.
- Latency:
  - ALU op: done is high in the 4th cycle after the start edge.
  - LOAD: 3 cycles + memory wait cycles.
- start while busy is ignored (not queued).
- Register aliasing:
  - ra=rb=rc is legal; sources are read before writeback.
  - dbg_data shows the old value until the T_WB/M_WB edge.
- No register is hard-wired to zero.

Decomposition:
- Package bus_datapath_pkg holds:
  - the op enum (op_t);
  - the state enum (state_t);
  - the bus-source select enum;
  - a WIDTH-independent RESERVED_OP_MIN=9 constant.
- One sub-module: bus_datapath_alu (combinational, Y/bus/op -> 2*WIDTH result).
- The register file stays inline.

Test Plan:
- Reset mid-op:
  - Stimulus: start ADD, assert clear during T_Z.
  - Required: busy=0, done=0, mem_req=0 immediately; all dbg_data reads 0.
  - Then ADD R1=5, R2=7 -> R3: done 4 cycles later, R3=12.
- SUB wrap: R1=0, R2=1 -> R4=0xFFFFFFFF; ZHI/HI unchanged (HI=0).
- MUL signed: R5=0xFFFFFFFE (-2), R6=3 -> R7=0xFFFFFFFA, lo_out=0xFFFFFFFA, hi_out=0xFFFFFFFF.
- SHL with 5-bit mask: R1=1, R2=33 -> R3=2.
- LOAD with wait states:
  - Setup: R1=0x40, mem_ack delayed 3 cycles, mem_rdata=0xDEADBEEF.
  - Required: mem_addr=0x40 and mem_req held for all 3 wait cycles; R2=0xDEADBEEF; done at cycle 6.
- Protocol edges:
  - start pulsed while busy: ignored, exactly one done.
  - Reserved op 12: done after 1 cycle, no register change.
  - ra=rb=rc=R3=4 with ADD: R3=8.

Source files
------------

// File: rtl/bus_datapath_pkg.sv
// Shared types and constants for the sequenced single-bus datapath.
//   op_t      : operation codes carried on the 'op' input (values 9..15 are reserved)
//   state_t   : micro-step sequencer states
//   bus_src_t : which storage element drives the internal bus
package bus_datapath_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_MUL  = 4'd6,
        OP_MOV  = 4'd7,
        OP_LOAD = 4'd8
    } op_t;

    // Any op code at or above this value is reserved: nothing is written,
    // but the request still completes with a done pulse.
    localparam logic [3:0] RESERVED_OP_MIN = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_T_Y   = 3'd1,
        S_T_Z   = 3'd2,
        S_T_WB  = 3'd3,
        S_M_REQ = 3'd4,
        S_M_WB  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        BUS_NONE = 3'd0,
        BUS_RA   = 3'd1,
        BUS_RB   = 3'd2,
        BUS_ZLO  = 3'd3,
        BUS_MDR  = 3'd4
    } bus_src_t;

endpackage

// File: rtl/bus_datapath_alu.sv
// Combinational ALU for the single-bus datapath.
//   op     : operation code (reserved codes and LOAD give zero)
//   y      : operand held in the Y register
//   b      : operand currently on the internal bus
//   result : 2*WIDTH-bit result, upper half (ZHI) non-zero only for MUL
module bus_datapath_alu
    import bus_datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   y,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] result
);

    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0]      shamt;
    logic [2*WIDTH-1:0] y_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] prod;

    // Only the low bits of the bus select the shift distance.
    assign shamt = b[SW-1:0];

    // Sign-extending both operands to 2*WIDTH makes the low 2*WIDTH bits of
    // an unsigned product equal to the signed product.
    assign y_ext = {{WIDTH{y[WIDTH-1]}}, y};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};
    assign prod  = y_ext * b_ext;

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result[WIDTH-1:0] = y + b;
            OP_SUB:  result[WIDTH-1:0] = y - b;
            OP_AND:  result[WIDTH-1:0] = y & b;
            OP_OR:   result[WIDTH-1:0] = y | b;
            OP_SHL:  result[WIDTH-1:0] = y << shamt;
            OP_SHR:  result[WIDTH-1:0] = y >> shamt;
            OP_MUL:  result            = prod;
            OP_MOV:  result[WIDTH-1:0] = b;
            default: result            = '0;
        endcase
    end

endmodule

// File: rtl/bus_datapath_seq.sv
// Single-bus CPU datapath with a built-in micro-step sequencer.
// A start pulse in IDLE latches op/ra/rb/rc and the sequencer then walks
// the bus transfers for one ALU op (T_Y, T_Z, T_WB) or one memory load
// (T_Y, M_REQ, M_WB), finishing with a one-cycle done pulse.
//   clock, clear           : clock and asynchronous active-high reset
//   start, op, ra, rb, rc  : request and operand/destination register selects
//   busy, done             : sequencer status
//   mem_req, mem_addr      : read request, address from MAR
//   mem_ack, mem_rdata     : read completion and data (captured into MDR)
//   dbg_sel, dbg_data      : combinational register file peek
//   hi_out, lo_out         : HI/LO registers written by MUL
module bus_datapath_seq
    import bus_datapath_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int NREGS = 16,
    localparam int RW    = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [RW-1:0]    ra,
    input  logic [RW-1:0]    rb,
    input  logic [RW-1:0]    rc,
    output logic             busy,
    output logic             done,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic [RW-1:0]    dbg_sel,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    state_t             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [RW-1:0]      ra_q, ra_d;
    logic [RW-1:0]      rb_q, rb_d;
    logic [RW-1:0]      rc_q, rc_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic [WIDTH-1:0]   zlo_q, zlo_d;
    logic [WIDTH-1:0]   zhi_q, zhi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   mar_q, mar_d;
    logic [WIDTH-1:0]   mdr_q, mdr_d;
    logic [WIDTH-1:0]   rf_q [NREGS];

    bus_src_t           bus_src;
    logic [WIDTH-1:0]   bus_val;
    logic [2*WIDTH-1:0] alu_result;
    logic               rf_we;

    // Bus source is a pure function of the current state, so exactly one
    // element drives the bus per step.
    always_comb begin
        bus_src = BUS_NONE;
        case (state_q)
            S_T_Y:   bus_src = BUS_RA;
            S_T_Z:   bus_src = BUS_RB;
            S_T_WB:  bus_src = BUS_ZLO;
            S_M_WB:  bus_src = BUS_MDR;
            default: bus_src = BUS_NONE;
        endcase
    end

    always_comb begin
        bus_val = '0;
        case (bus_src)
            BUS_RA:  bus_val = rf_q[ra_q];
            BUS_RB:  bus_val = rf_q[rb_q];
            BUS_ZLO: bus_val = zlo_q;
            BUS_MDR: bus_val = mdr_q;
            default: bus_val = '0;
        endcase
    end

    bus_datapath_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_q),
        .y      (y_q),
        .b      (bus_val),
        .result (alu_result)
    );

    // Next-state and datapath update logic.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        y_d     = y_q;
        zlo_d   = zlo_q;
        zhi_d   = zhi_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        rf_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    ra_d    = ra;
                    rb_d    = rb;
                    rc_d    = rc;
                    state_d = (op >= RESERVED_OP_MIN) ? S_DONE : S_T_Y;
                end
            end
            S_T_Y: begin
                if (op_q == OP_LOAD) begin
                    mar_d   = bus_val;
                    state_d = S_M_REQ;
                end else begin
                    y_d     = bus_val;
                    state_d = S_T_Z;
                end
            end
            S_T_Z: begin
                zlo_d   = alu_result[WIDTH-1:0];
                zhi_d   = alu_result[2*WIDTH-1:WIDTH];
                state_d = S_T_WB;
            end
            S_T_WB: begin
                rf_we = 1'b1;
                if (op_q == OP_MUL) begin
                    lo_d = zlo_q;
                    hi_d = zhi_q;
                end
                state_d = S_DONE;
            end
            S_M_REQ: begin
                if (mem_ack) begin
                    mdr_d   = mem_rdata;
                    state_d = S_M_WB;
                end
            end
            S_M_WB: begin
                rf_we   = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            y_q     <= '0;
            zlo_q   <= '0;
            zhi_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
            y_q     <= y_d;
            zlo_q   <= zlo_d;
            zhi_q   <= zhi_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
        end
    end

    // Register file: cleared by reset, so it is kept in flops rather than RAM.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rc_q] <= bus_val;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign mem_req  = (state_q == S_M_REQ);
    assign mem_addr = mar_q;
    assign dbg_data = rf_q[dbg_sel];
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed testbench for bus_datapath_seq. Registers are preset through
// LOAD operations addressed by R0 (which stays zero throughout).
module tb_bus_datapath_seq;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          clear;
    logic          start;
    logic [3:0]    op;
    logic [3:0]    ra, rb, rc;
    logic          busy, done, mem_req;
    logic [W-1:0]  mem_addr;
    logic          mem_ack;
    logic [W-1:0]  mem_rdata;
    logic [3:0]    dbg_sel;
    logic [W-1:0]  dbg_data, hi_out, lo_out;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    bus_datapath_seq #(.WIDTH(32), .NREGS(16)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .op        (op),
        .ra        (ra),
        .rb        (rb),
        .rc        (rc),
        .busy      (busy),
        .done      (done),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (done) done_cnt++;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic read_reg(input logic [3:0] r, input logic [31:0] exp, input string tag);
        dbg_sel = r;
        #1;
        check_eq(tag, {32'd0, dbg_data}, {32'd0, exp});
    endtask

    // Issue one request and follow it to completion. ack_at selects in
    // which M_REQ cycle mem_ack is raised; old_val (if chk_old) is the value
    // R[rc] must still show during T_WB.
    task automatic run_op(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] c, input int ack_at, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input int exp_cycles, input string tag,
                          input bit chk_old, input logic [31:0] old_val);
        int cnt;
        int nreq;
        op = o; ra = a; rb = b; rc = c; dbg_sel = c;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        cnt  = 1;
        nreq = 0;
        while (!done && cnt < 40) begin
            if (mem_req) begin
                nreq++;
                check_eq({tag, " mem_addr"}, {32'd0, mem_addr}, {32'd0, exp_addr});
                if (nreq >= ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
            end
            if (chk_old && cnt == 3)
                check_eq({tag, " old value in T_WB"}, {32'd0, dbg_data}, {32'd0, old_val});
            @(posedge clock); #1;
            mem_ack = 1'b0;
            cnt++;
        end
        check_eq({tag, " done cycle"}, 64'(cnt), 64'(exp_cycles));
        if (o == 4'd8)
            check_eq({tag, " mem_req cycles"}, 64'(nreq), 64'(ack_at));
        @(posedge clock); #1;
        check_eq({tag, " idle after done"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic load_reg(input logic [3:0] c, input logic [31:0] val, input string tag);
        run_op(4'd8, 4'd0, 4'd0, c, 1, val, 32'd0, 4, tag, 1'b0, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        clear = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0;
        mem_ack = 1'b0; mem_rdata = '0; dbg_sel = '0;
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset busy", {63'd0, busy}, 64'd0);
        check_eq("reset done", {63'd0, done}, 64'd0);
        check_eq("reset mem_req", {63'd0, mem_req}, 64'd0);
        check_eq("reset hi", {32'd0, hi_out}, 64'd0);
        check_eq("reset lo", {32'd0, lo_out}, 64'd0);
        clear = 1'b0;
        @(posedge clock); #1;

        // Reset in the middle of an ADD.
        load_reg(4'd1, 32'd5, "ld R1=5");
        op = 4'd0; ra = 4'd1; rb = 4'd2; rc = 4'd3; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;   // T_Y
        @(posedge clock); #1;                 // T_Z
        clear = 1'b1;
        #1;
        check_eq("midop clear busy", {63'd0, busy}, 64'd0);
        check_eq("midop clear done", {63'd0, done}, 64'd0);
        check_eq("midop clear mem_req", {63'd0, mem_req}, 64'd0);
        for (int r = 0; r < 16; r++) read_reg(4'(r), 32'd0, $sformatf("cleared R%0d", r));
        @(posedge clock); #1;
        clear = 1'b0;
        @(posedge clock); #1;

        // ADD
        load_reg(4'd1, 32'd5, "ld R1=5");
        load_reg(4'd2, 32'd7, "ld R2=7");
        run_op(4'd0, 4'd1, 4'd2, 4'd3, 0, 0, 0, 4, "ADD", 1'b0, 0);
        read_reg(4'd3, 32'd12, "ADD R3");

        // SUB wrap
        load_reg(4'd1, 32'd0, "ld R1=0");
        load_reg(4'd2, 32'd1, "ld R2=1");
        run_op(4'd1, 4'd1, 4'd2, 4'd4, 0, 0, 0, 4, "SUB", 1'b0, 0);
        read_reg(4'd4, 32'hFFFF_FFFF, "SUB R4");
        check_eq("SUB hi unchanged", {32'd0, hi_out}, 64'd0);

        // MUL signed, then other ALU ops on the same operands
        load_reg(4'd5, 32'hFFFF_FFFE, "ld R5=-2");
        load_reg(4'd6, 32'd3, "ld R6=3");
        run_op(4'd6, 4'd5, 4'd6, 4'd7, 0, 0, 0, 4, "MUL", 1'b0, 0);
        read_reg(4'd7, 32'hFFFF_FFFA, "MUL R7");
        check_eq("MUL lo", {32'd0, lo_out}, {32'd0, 32'hFFFF_FFFA});
        check_eq("MUL hi", {32'd0, hi_out}, {32'd0, 32'hFFFF_FFFF});
        run_op(4'd2, 4'd5, 4'd6, 4'd8, 0, 0, 0, 4, "AND", 1'b0, 0);
        read_reg(4'd8, 32'd2, "AND R8");
        run_op(4'd3, 4'd5, 4'd6, 4'd11, 0, 0, 0, 4, "OR", 1'b0, 0);
        read_reg(4'd11, 32'hFFFF_FFFF, "OR R11");
        run_op(4'd5, 4'd4, 4'd6, 4'd10, 0, 0, 0, 4, "SHR", 1'b0, 0);
        read_reg(4'd10, 32'h1FFF_FFFF, "SHR R10");
        run_op(4'd7, 4'd5, 4'd6, 4'd12, 0, 0, 0, 4, "MOV", 1'b0, 0);
        read_reg(4'd12, 32'd3, "MOV R12");

        // SHL with masked shift amount
        load_reg(4'd1, 32'd1, "ld R1=1");
        load_reg(4'd2, 32'd33, "ld R2=33");
        run_op(4'd4, 4'd1, 4'd2, 4'd3, 0, 0, 0, 4, "SHL", 1'b0, 0);
        read_reg(4'd3, 32'd2, "SHL R3");
        check_eq("SHL hi unchanged", {32'd0, hi_out}, {32'd0, 32'hFFFF_FFFF});

        // LOAD with memory wait cycles
        load_reg(4'd1, 32'h40, "ld R1=0x40");
        run_op(4'd8, 4'd1, 4'd0, 4'd2, 3, 32'hDEAD_BEEF, 32'h40, 6, "LOAD wait", 1'b0, 0);
        read_reg(4'd2, 32'hDEAD_BEEF, "LOAD R2");

        // start while busy is ignored
        d0 = done_cnt;
        op = 4'd0; ra = 4'd1; rb = 4'd1; rc = 4'd8; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        @(posedge clock); #1;
        op = 4'd1; rc = 4'd9; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        check_eq("busy start done count", 64'(done_cnt - d0), 64'd1);
        read_reg(4'd8, 32'h80, "busy start R8");
        read_reg(4'd9, 32'd0, "busy start R9 untouched");

        // Reserved op
        run_op(4'd12, 4'd1, 4'd2, 4'd1, 0, 0, 0, 1, "RSVD", 1'b0, 0);
        read_reg(4'd1, 32'h40, "RSVD R1");
        read_reg(4'd2, 32'hDEAD_BEEF, "RSVD R2");

        // Aliasing ra=rb=rc
        load_reg(4'd3, 32'd4, "ld R3=4");
        run_op(4'd0, 4'd3, 4'd3, 4'd3, 0, 0, 0, 4, "ALIAS", 1'b1, 32'd4);
        read_reg(4'd3, 32'd8, "ALIAS R3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
